// File: rtl/source_scanner_pkg.sv
// Shared constants for the text scanner: external status codes and internal FSM states.
package source_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_SUCCESS = 2'd2,
    ST_ERROR   = 2'd3
  } scanner_status_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_NEW_LINE = 3'd1,
    S_SEND     = 3'd2,
    S_DRAIN    = 3'd3,
    S_SUCCESS  = 3'd4,
    S_ERROR    = 3'd5
  } assembler_state_t;

  function automatic scanner_status_t status_of(input assembler_state_t s);
    case (s)
      S_NEW_LINE, S_SEND, S_DRAIN: return ST_BUSY;
      S_SUCCESS:                   return ST_SUCCESS;
      S_ERROR:                     return ST_ERROR;
      default:                     return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/source_scanner_delay.sv
// Aligns issued-address tags (line, column) and their valid with memory read data.
module scan_delay_line #(
  parameter int LATENCY = 2,
  parameter int WIDTH   = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             i_squash,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_data
);

  logic [LATENCY-1:0] r_vld;
  logic [WIDTH-1:0]   r_data [LATENCY];

  // A squash empties every stage, including the entry offered this cycle.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_vld <= '0;
    end else if (i_squash) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= i_vld;
      for (int i = 1; i < LATENCY; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  always_ff @(posedge clk_in) begin
    r_data[0] <= i_data;
    for (int i = 1; i < LATENCY; i++) r_data[i] <= r_data[i-1];
  end

  assign o_vld  = r_vld[LATENCY-1];
  assign o_data = r_data[LATENCY-1];

endmodule

// File: rtl/source_scanner.sv
// Streams a text memory line by line to a consumer, with early line termination, abort and restart.
module source_scanner
  import source_scanner_pkg::*;
#(
  parameter  int CHAR_PER_LINE = 64,
  parameter  int NUMBER_LINES  = 256,
  parameter  int READ_LATENCY  = 2,
  parameter  int NUM_PASSES    = 2,
  localparam int ADDR_W        = $clog2(CHAR_PER_LINE*NUMBER_LINES),
  localparam int LINE_W        = $clog2(NUMBER_LINES),
  localparam int COL_W         = $clog2(CHAR_PER_LINE)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic              line_done_in,
  input  logic              error_in,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic [7:0]        mem_data_in,
  output logic              new_line_out,
  output logic              char_valid_out,
  output logic [7:0]        char_out,
  output logic [LINE_W-1:0] line_count_out,
  output logic [COL_W-1:0]  char_count_out,
  output logic [1:0]        pass_out,
  output scanner_status_t   status_out
);

  assembler_state_t  r_state, w_state_nxt;
  logic [LINE_W-1:0] r_line, w_line_nxt;
  logic [COL_W-1:0]  r_col, w_col_nxt;
  logic [1:0]        r_pass, w_pass_nxt;
  logic [2:0]        r_drain, w_drain_nxt;
  logic              w_busy, w_squash, w_issue, w_line_end;
  logic              w_d_vld;
  logic [LINE_W-1:0] w_d_line;
  logic [COL_W-1:0]  w_d_col;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
      r_line  <= '0;
      r_col   <= '0;
      r_pass  <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_line  <= w_line_nxt;
      r_col   <= w_col_nxt;
      r_pass  <= w_pass_nxt;
      r_drain <= w_drain_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_line_nxt  = r_line;
    w_col_nxt   = r_col;
    w_pass_nxt  = r_pass;
    w_drain_nxt = r_drain;
    w_squash    = 1'b0;
    w_issue     = 1'b0;
    w_line_end  = 1'b0;
    w_busy      = (r_state == S_NEW_LINE) || (r_state == S_SEND) || (r_state == S_DRAIN);

    // Priority: start, then error (busy only), then line_done / normal sequencing.
    if (start_in) begin
      w_state_nxt = S_NEW_LINE;
      w_line_nxt  = '0;
      w_col_nxt   = '0;
      w_pass_nxt  = '0;
      w_squash    = 1'b1;
    end else if (w_busy && error_in) begin
      w_state_nxt = S_ERROR;
      w_squash    = 1'b1;
    end else begin
      case (r_state)
        S_NEW_LINE: begin
          w_state_nxt = S_SEND;
          w_col_nxt   = '0;
        end
        S_SEND: begin
          if (line_done_in) begin
            w_squash   = 1'b1;
            w_line_end = 1'b1;
          end else begin
            w_issue = 1'b1;
            if (r_col == COL_W'(CHAR_PER_LINE-1)) begin
              w_state_nxt = S_DRAIN;
              w_drain_nxt = '0;
            end else begin
              w_col_nxt = r_col + COL_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (line_done_in) begin
            w_squash   = 1'b1;
            w_line_end = 1'b1;
          end else if (r_drain == 3'(READ_LATENCY-1)) begin
            w_line_end = 1'b1;
          end else begin
            w_drain_nxt = r_drain + 3'd1;
          end
        end
        default: ;
      endcase
    end

    if (w_line_end) begin
      w_col_nxt = '0;
      if (r_line == LINE_W'(NUMBER_LINES-1)) begin
        if (r_pass < 2'(NUM_PASSES-1)) begin
          w_state_nxt = S_NEW_LINE;
          w_line_nxt  = '0;
          w_pass_nxt  = r_pass + 2'd1;
        end else begin
          w_state_nxt = S_SUCCESS;
        end
      end else begin
        w_state_nxt = S_NEW_LINE;
        w_line_nxt  = r_line + LINE_W'(1);
      end
    end
  end

  scan_delay_line #(
    .LATENCY (READ_LATENCY),
    .WIDTH   (LINE_W + COL_W)
  ) u_delay (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .i_squash (w_squash),
    .i_vld    (w_issue),
    .i_data   ({r_line, r_col}),
    .o_vld    (w_d_vld),
    .o_data   ({w_d_line, w_d_col})
  );

  assign mem_addr_out   = ADDR_W'(r_line) * ADDR_W'(CHAR_PER_LINE) + ADDR_W'(r_col);
  assign new_line_out   = (r_state == S_NEW_LINE);
  assign char_valid_out = w_d_vld && w_busy;
  assign char_out       = char_valid_out ? mem_data_in : 8'd0;
  assign line_count_out = char_valid_out ? w_d_line : r_line;
  assign char_count_out = char_valid_out ? w_d_col : '0;
  assign pass_out       = r_pass;
  assign status_out     = status_of(r_state);

endmodule

// File: tb/tb_source_scanner.sv
// Randomized line-termination scans of the text scanner checked against a stream-level model.
module tb_source_scanner;
  import source_scanner_pkg::*;

  typedef struct {
    int pass;
    int line;
    int col;
    int ch;
  } item_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, ld_a, err_a, start_b, ld_b, err_b;
  logic [4:0] addr_a, addr_b;
  logic [7:0] mem_a, mem_b;
  logic nl_a, cv_a, nl_b, cv_b;
  logic [7:0] co_a, co_b;
  logic [1:0] lc_a, lc_b, pass_a, pass_b;
  logic [2:0] cc_a, cc_b;
  scanner_status_t st_a, st_b;

  logic [4:0] pipe_a [2];
  logic [4:0] pipe_b [4];

  item_t got_a[$];
  item_t got_b[$];
  item_t exp_q[$];
  int n_chk = 0;
  int n_err = 0;
  int dc [8];

  always #5 clk = ~clk;

  source_scanner #(.CHAR_PER_LINE(8), .NUMBER_LINES(4), .READ_LATENCY(2), .NUM_PASSES(2)) u_dut_a (
    .clk_in(clk), .rst_in(rst_n), .start_in(start_a), .line_done_in(ld_a), .error_in(err_a),
    .mem_addr_out(addr_a), .mem_data_in(mem_a), .new_line_out(nl_a), .char_valid_out(cv_a),
    .char_out(co_a), .line_count_out(lc_a), .char_count_out(cc_a), .pass_out(pass_a),
    .status_out(st_a));

  source_scanner #(.CHAR_PER_LINE(8), .NUMBER_LINES(4), .READ_LATENCY(4), .NUM_PASSES(1)) u_dut_b (
    .clk_in(clk), .rst_in(rst_n), .start_in(start_b), .line_done_in(ld_b), .error_in(err_b),
    .mem_addr_out(addr_b), .mem_data_in(mem_b), .new_line_out(nl_b), .char_valid_out(cv_b),
    .char_out(co_b), .line_count_out(lc_b), .char_count_out(cc_b), .pass_out(pass_b),
    .status_out(st_b));

  // Text memory: byte = address, registered read pipeline of the configured latency.
  always @(posedge clk) begin
    pipe_a[0] <= addr_a;
    pipe_a[1] <= pipe_a[0];
    pipe_b[0] <= addr_b;
    for (int i = 1; i < 4; i++) pipe_b[i] <= pipe_b[i-1];
  end
  assign mem_a = {3'b000, pipe_a[1]};
  assign mem_b = {3'b000, pipe_b[3]};

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (cv_a) got_a.push_back('{int'(pass_a), int'(lc_a), int'(cc_a), int'(co_a)});
    if (cv_b) got_b.push_back('{int'(pass_b), int'(lc_b), int'(cc_b), int'(co_b)});
  endtask

  // Expected stream: line_done seen while column k is issued (k counted from the first SEND
  // cycle, drain cycles continuing the count) delivers columns 0..k-latency of that line.
  task automatic build_exp(input int d [8], input int np, input int rl);
    exp_q.delete();
    for (int p = 0; p < np; p++)
      for (int l = 0; l < 4; l++) begin
        int last;
        last = (d[p*4+l] < 0) ? 7 : d[p*4+l] - rl;
        if (last > 7) last = 7;
        for (int c = 0; c <= last; c++) exp_q.push_back('{p, l, c, l*8 + c});
      end
  endtask

  task automatic compare_q(input string tag, input item_t got[$]);
    int n;
    check_eq({tag, "_count"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_pos"}, (got[i].pass << 16) | (got[i].line << 8) | got[i].col,
               (exp_q[i].pass << 16) | (exp_q[i].line << 8) | exp_q[i].col);
      check_eq({tag, "_char"}, got[i].ch, (got[i].line * 8 + got[i].col) & 8'hff);
    end
  endtask

  task automatic wait_status_a(input string tag, input scanner_status_t s, input int bound);
    int w = 0;
    while (st_a != s && w < bound) begin tick(); w++; end
    check_eq({tag, "_status"}, int'(st_a), int'(s));
  endtask

  task automatic wait_nl(input string tag, input int p, input int l, input int bound);
    int w = 0;
    while (!(nl_a && int'(pass_a) == p && int'(lc_a) == l) && w < bound) begin tick(); w++; end
    check_eq({tag, "_nl_seen"}, int'(nl_a), 1);
  endtask

  task automatic run_scan(input string tag, input int d [8]);
    got_a.delete();
    start_a = 1'b1; tick(); start_a = 1'b0;
    for (int idx = 0; idx < 8; idx++) begin
      wait_nl(tag, idx / 4, idx % 4, 40);
      check_eq({tag, "_nl_line"}, int'(lc_a), idx % 4);
      check_eq({tag, "_nl_pass"}, int'(pass_a), idx / 4);
      if (d[idx] >= 0) begin
        repeat (d[idx] + 1) tick();
        if (d[idx] < 8) check_eq({tag, "_addr"}, int'(addr_a), (idx % 4) * 8 + d[idx]);
        ld_a = 1'b1; tick(); ld_a = 1'b0;
      end else begin
        tick();
      end
    end
    wait_status_a(tag, ST_SUCCESS, 100);
    build_exp(d, 2, 2);
    compare_q(tag, got_a);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    {start_a, ld_a, err_a, start_b, ld_b, err_b} = '0;
    tick(); tick();
    check_eq("rst_status", int'(st_a), int'(ST_IDLE));
    check_eq("rst_outs", int'({nl_a, cv_a, co_a, addr_a, lc_a, cc_a, pass_a}), 0);
    rst_n = 1'b1;
    tick();
    check_eq("idle_status", int'(st_a), int'(ST_IDLE));

    // Full clean scan with exact first-character timing.
    got_a.delete();
    start_a = 1'b1; tick(); start_a = 1'b0;
    check_eq("c1_new_line", int'(nl_a), 1);
    check_eq("c1_line", int'(lc_a), 0);
    check_eq("c1_status", int'(st_a), int'(ST_BUSY));
    tick();
    check_eq("c2_addr", int'(addr_a), 0);
    check_eq("c2_new_line", int'(nl_a), 0);
    tick();
    check_eq("c3_valid", int'(cv_a), 0);
    tick();
    check_eq("c4_valid", int'(cv_a), 1);
    check_eq("c4_char", int'(co_a), 0);
    check_eq("c4_col", int'(cc_a), 0);
    wait_status_a("clean", ST_SUCCESS, 200);
    dc = '{default: -1};
    build_exp(dc, 2, 2);
    compare_q("clean", got_a);
    check_eq("success_nl", int'(nl_a), 0);

    // line_done during column 3 of line 1.
    dc = '{default: -1};
    dc[1] = 3;
    run_scan("ld_l1c3", dc);

    // Randomized early terminations, including drain cycles.
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 8; i++) dc[i] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 9)) : -1;
      run_scan("rand", dc);
    end

    // Error during pass 1, line 2.
    got_a.delete();
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_nl("err", 1, 2, 300);
    repeat (3) tick();
    err_a = 1'b1; tick(); err_a = 1'b0;
    check_eq("err_status", int'(st_a), int'(ST_ERROR));
    n = got_a.size();
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("err_hold", int'(st_a), int'(ST_ERROR));
    end
    check_eq("err_no_valid", got_a.size(), n);

    // Restart mid-scan at pass 0, line 3.
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_nl("rs", 0, 3, 100);
    repeat (4) tick();
    got_a.delete();
    start_a = 1'b1; tick(); start_a = 1'b0;
    check_eq("rs_new_line", int'(nl_a), 1);
    check_eq("rs_line", int'(lc_a), 0);
    check_eq("rs_pass", int'(pass_a), 0);
    wait_status_a("rs", ST_SUCCESS, 200);
    dc = '{default: -1};
    build_exp(dc, 2, 2);
    compare_q("restart", got_a);

    // start and error together from SUCCESS.
    start_a = 1'b1; err_a = 1'b1; tick(); start_a = 1'b0; err_a = 1'b0;
    check_eq("se_status", int'(st_a), int'(ST_BUSY));
    check_eq("se_new_line", int'(nl_a), 1);

    // Reset pulse in the first drain cycle of line 0.
    repeat (9) tick();
    check_eq("pre_rst_status", int'(st_a), int'(ST_BUSY));
    rst_n = 1'b0;
    #1;
    check_eq("arst_status", int'(st_a), int'(ST_IDLE));
    check_eq("arst_nl_cv", int'({nl_a, cv_a}), 0);
    check_eq("arst_char", int'(co_a), 0);
    check_eq("arst_addr", int'(addr_a), 0);
    check_eq("arst_counts", int'({lc_a, cc_a, pass_a}), 0);
    tick();
    rst_n = 1'b1;
    n = got_a.size();
    tick();
    check_eq("post_rst_status", int'(st_a), int'(ST_IDLE));
    repeat (6) tick();
    check_eq("post_rst_no_valid", got_a.size(), n);

    // Latency 4, single pass.
    got_b.delete();
    start_b = 1'b1; tick(); start_b = 1'b0;
    begin
      int w = 0;
      while (st_b != ST_SUCCESS && w < 300) begin tick(); w++; end
    end
    check_eq("lat4_status", int'(st_b), int'(ST_SUCCESS));
    dc = '{default: -1};
    build_exp(dc, 1, 4);
    compare_q("lat4", got_b);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/source_scanner.md
SOURCE_SCANNER -- requirements
Module: source_scanner

Interface
REQ-001 SHALL have parameter CHAR_PER_LINE, default 64, characters per text line.
REQ-002 SHALL have parameter NUMBER_LINES, default 256, lines in the text memory.
REQ-003 SHALL have parameter READ_LATENCY, default 2, cycles from mem_addr_out to valid mem_data_in (range 1..4).
REQ-004 SHALL have parameter NUM_PASSES, default 2, full scans of the text per start (range 1..4).
REQ-005 SHALL have port clk_in, input, 1: the single clock.
REQ-006 SHALL have port rst_in, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port start_in, input, 1: one-cycle start pulse.
REQ-008 SHALL have port line_done_in, input, 1: consumer reports the current line finished early.
REQ-009 SHALL have port error_in, input, 1: consumer reports a fatal error.
REQ-010 SHALL have port mem_addr_out, output, $clog2(CHAR_PER_LINE*NUMBER_LINES): text memory read address.
REQ-011 SHALL have port mem_data_in, input, 8: text memory read data.
REQ-012 SHALL have port new_line_out, output, 1: one-cycle pulse before each line's characters.
REQ-013 SHALL have port char_valid_out, output, 1: char_out is valid this cycle.
REQ-014 SHALL have port char_out, output, 8: character delivered to the consumer.
REQ-015 SHALL have port line_count_out, output, $clog2(NUMBER_LINES): line of the current or delivered character.
REQ-016 SHALL have port char_count_out, output, $clog2(CHAR_PER_LINE): column of the delivered character.
REQ-017 SHALL have port pass_out, output, 2: current pass index.
REQ-018 SHALL have port status_out, output, scanner_status_t: IDLE, BUSY, SUCCESS or ERROR.

Function
REQ-019 SHALL implement states IDLE, NEW_LINE, SEND, DRAIN, SUCCESS and ERROR; status_out is BUSY in NEW_LINE, SEND and DRAIN.
REQ-020 SHALL, on start_in in any state, go to NEW_LINE next cycle with pass 0 and line 0, and squash all in-flight reads.
REQ-021 SHALL hold NEW_LINE for exactly one cycle with new_line_out=1 and line_count_out equal to the new line.
REQ-022 SHALL, in SEND, issue one address per cycle, mem_addr_out = line*CHAR_PER_LINE + col, with col running from 0.
REQ-023 SHALL assert char_valid_out exactly READ_LATENCY cycles after each issued address, with char_out=mem_data_in and char_count_out/line_count_out equal to that address's column and line.
REQ-024 SHALL, after issuing col=CHAR_PER_LINE-1, enter DRAIN for READ_LATENCY cycles so every in-flight character is delivered.
REQ-025 SHALL, on line_done_in in SEND or DRAIN, squash all in-flight reads and go directly to the next line; no further char_valid_out for that line.
REQ-026 SHALL treat line_done_in and col=CHAR_PER_LINE-1 in the same cycle as line_done_in.
REQ-027 SHALL, after line NUMBER_LINES-1 ends, go to NEW_LINE at line 0 with pass+1 if pass<NUM_PASSES-1, else to SUCCESS.
REQ-028 SHALL, on error_in while BUSY, go to ERROR next cycle and squash in-flight reads.
REQ-029 SHALL ignore error_in and line_done_in in IDLE, SUCCESS and ERROR.
REQ-030 SHALL give start_in priority over error_in in the same cycle, and error_in priority over line_done_in.
REQ-031 SHALL hold SUCCESS and ERROR until start_in or reset.
REQ-032 SHALL keep new_line_out and char_valid_out low outside BUSY states.

Reset
REQ-033 SHALL, while rst_in=0, asynchronously force IDLE, clear all counters and pipeline valids, and drive every output to 0 (status_out=IDLE).
REQ-034 SHALL, on reset mid-scan, deliver no stale characters after release.

Structure
REQ-035 SHALL take scanner_status_t from the shared constants package, alongside assembler_state_t.
REQ-036 SHALL implement valid/line/column alignment in one sub-module, scan_delay_line, parametrised by READ_LATENCY and width, with a squash input.

Verification (CHAR_PER_LINE=8, NUMBER_LINES=4, READ_LATENCY=2, NUM_PASSES=2; memory byte = address)
REQ-037 SHALL check: start at cycle 0 -> new_line_out at cycle 1, address 0 at cycle 2, char_valid with char_out=0x00 at cycle 4; 64 valids total, then status SUCCESS.
REQ-038 SHALL check: line_done_in during the cycle col 3 of line 1 is issued -> no valid for line 1 after that cycle; next new_line_out has line_count_out=2.
REQ-039 SHALL check: error_in during pass 1, line 2 -> ERROR next cycle, no further char_valid_out, and ERROR held for 20 cycles.
REQ-040 SHALL check: start_in during pass 0, line 3 -> restart at pass 0, line 0 with no stale valids; start_in and error_in together -> BUSY.
REQ-041 SHALL check: rst_in low for 1 cycle mid-DRAIN -> all outputs 0 immediately, IDLE after release.
REQ-042 SHALL check: with READ_LATENCY=4 and NUM_PASSES=1 -> 32 valids, each with char_out = line*8+col.
